dbus_uart: RTL and testbench



---
 rtl/dbus_uart_pkg.sv | 29 ++
 rtl/if_dbus.sv | 19 +
 rtl/dbus_uart_sync_fifo.sv | 47 ++++
 rtl/dbus_uart.sv | 354 +++++++++++++++++++++++++++++++++++
 tb/tb_dbus_uart.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_uart_pkg.sv
// dbus_uart shared types: register offsets, bit positions, FSM states.
// Optional loopback build: define DBUS_UART_LOOPBACK_EN.
package dbus_uart_pkg;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIV    = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

    localparam int ST_TX_EMPTY   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_FRAME_ERR  = 5;
    localparam int ST_TX_DROP    = 6;

    localparam int CTRL_TX_IE    = 0;
    localparam int CTRL_FIFO_CLR = 1;
    localparam int CTRL_LOOPBACK = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/if_dbus.sv
// Data-bus interface between the J1 core (master) and its responders.
// Word addressed; read data is returned one cycle after re.
interface if_dbus;
    logic [15:0] adr;
    logic        re;
    logic        we;
    logic [15:0] dat_o;
    logic [15:0] dat_i;

    modport master (
        output adr, re, we, dat_o,
        input  dat_i
    );

    modport slave (
        input  adr, re, we, dat_o,
        output dat_i
    );
endinterface

// File: rtl/dbus_uart_sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers and a clear strobe.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer advance; clear drops every stored entry at once.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + ONE;
        end
    end

    // Entry storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/dbus_uart.sv
// Memory-mapped 8N1 UART responder for the J1 data bus.
// Define DBUS_UART_LOOPBACK_EN to add the CTRL[2] internal loopback.
module dbus_uart
    import dbus_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADR  = 16'h2000,
    parameter int          TX_DEPTH  = 4,
    parameter int          RX_DEPTH  = 4,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic  clk,
    input  logic  reset_n,
    if_dbus.slave dbus,
    output logic  txd,
    input  logic  rxd,
    output logic  irq
);
    logic        hit;
    logic [1:0]  off;
    logic        rd_hit;
    logic        wr_hit;
    logic        wr_data;
    logic        wr_div;
    logic        wr_ctrl;
    logic        rd_data;
    logic        rd_status;
    logic        fifo_clr;

    logic [15:0] div;
    logic        tx_ie;
    logic [15:0] rdata;
    logic [15:0] rd_val;
    logic [15:0] status;
    logic [15:0] ctrl_rd;

    logic        rx_overrun;
    logic        frame_err;
    logic        tx_drop;

    logic        tx_push;
    logic        tx_pop;
    logic [7:0]  tx_dout;
    logic        tx_full;
    logic        tx_fifo_empty;
    logic        tx_empty;

    logic        rx_push;
    logic        rx_pop;
    logic [7:0]  rx_dout;
    logic        rx_full;
    logic        rx_empty;

    uart_state_t tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_line;

    uart_state_t rx_state;
    logic [15:0] rx_cnt;
    logic [15:0] rx_wait;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_in;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    logic        rx_wait_hi;
    logic        rx_stop_now;
    logic        ovr_set;
    logic        ferr_set;

    assign hit    = (dbus.adr[15:2] == BASE_ADR[15:2]);
    assign off    = dbus.adr[1:0];
    assign rd_hit = dbus.re && hit;
    assign wr_hit = dbus.we && hit;

    assign wr_data   = wr_hit && (off == UART_DATA);
    assign wr_div    = wr_hit && (off == UART_DIV);
    assign wr_ctrl   = wr_hit && (off == UART_CTRL);
    assign rd_data   = rd_hit && (off == UART_DATA);
    assign rd_status = rd_hit && (off == UART_STATUS);
    assign fifo_clr  = wr_ctrl && dbus.dat_o[CTRL_FIFO_CLR];

`ifdef DBUS_UART_LOOPBACK_EN
    logic loop_en;

    // Loopback select bit, written through CTRL.
    always_ff @(posedge clk) begin
        if (!reset_n)
            loop_en <= 1'b0;
        else if (wr_ctrl)
            loop_en <= dbus.dat_o[CTRL_LOOPBACK];
    end

    assign txd     = loop_en ? 1'b1 : tx_line;
    assign rx_in   = loop_en ? tx_line : rxd;
    assign ctrl_rd = {13'b0, loop_en, 1'b0, tx_ie};
`else
    assign txd     = tx_line;
    assign rx_in   = rxd;
    assign ctrl_rd = {15'b0, tx_ie};
`endif

    assign tx_empty = tx_fifo_empty && (tx_state == IDLE);
    assign irq      = !rx_empty || (tx_empty && tx_ie);

    assign tx_push = wr_data && !tx_full;
    assign tx_pop  = !tx_fifo_empty && !fifo_clr &&
                     ((tx_state == IDLE) ||
                      (tx_state == STOP && tx_cnt == 16'd0));

    assign rx_pop      = rd_data && !rx_empty;
    assign rx_stop_now = (rx_state == STOP) && (rx_cnt == 16'd0);
    assign rx_push     = rx_stop_now && rx_s2 && !rx_full;
    assign ovr_set     = rx_stop_now && rx_s2 && rx_full;
    assign ferr_set    = rx_stop_now && !rx_s2;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (fifo_clr),
        .push    (tx_push),
        .din     (dbus.dat_o[7:0]),
        .pop     (tx_pop),
        .dout    (tx_dout),
        .full    (tx_full),
        .empty   (tx_fifo_empty)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (fifo_clr),
        .push    (rx_push),
        .din     (rx_sh),
        .pop     (rx_pop),
        .dout    (rx_dout),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    // Assemble the STATUS word from live flags and sticky bits.
    always_comb begin
        status                = '0;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_TX_FULL]    = tx_full;
        status[ST_RX_VALID]   = !rx_empty;
        status[ST_RX_FULL]    = rx_full;
        status[ST_RX_OVERRUN] = rx_overrun;
        status[ST_FRAME_ERR]  = frame_err;
        status[ST_TX_DROP]    = tx_drop;
    end

    // Register read mux, always reflecting pre-write state.
    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            (off == UART_DATA):
                rd_val = rx_empty ? 16'h0000 : {8'h80, rx_dout};
            (off == UART_STATUS):
                rd_val = status;
            (off == UART_DIV):
                rd_val = div;
            (off == UART_CTRL):
                rd_val = ctrl_rd;
        endcase
    end

    // Half-bit wait in clocks minus one, for centring RX samples.
    always_comb begin
        rx_wait = '0;
        if (div[0])
            rx_wait = div >> 1;
        else if (div >= 16'd2)
            rx_wait = (div >> 1) - 16'd1;
    end

    // Read data register: one cycle of data, zero otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n)
            rdata <= '0;
        else
            rdata <= rd_hit ? rd_val : 16'h0000;
    end

    assign dbus.dat_i = rdata;

    // Writable control registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div   <= DIV_RESET;
            tx_ie <= 1'b0;
        end else begin
            if (wr_div)
                div <= dbus.dat_o;
            if (wr_ctrl)
                tx_ie <= dbus.dat_o[CTRL_TX_IE];
        end
    end

    // Sticky error flags; a same-cycle set beats the read clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            rx_overrun <= ovr_set || (rx_overrun && !rd_status);
            frame_err  <= ferr_set || (frame_err && !rd_status);
            tx_drop    <= (wr_data && tx_full) ||
                          (tx_drop && !rd_status);
        end
    end

    // TX shifter: start, 8 data bits LSB first, stop, chain next byte.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_state <= IDLE;
            tx_line  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else begin
            unique case (tx_state)
                IDLE: begin
                    tx_line <= 1'b1;
                    if (tx_pop) begin
                        tx_sh    <= tx_dout;
                        tx_cnt   <= div;
                        tx_line  <= 1'b0;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt   <= div;
                        tx_bit   <= '0;
                        tx_line  <= tx_sh[0];
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= div;
                        if (tx_bit == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_bit  <= tx_bit + 3'd1;
                            tx_sh   <= {1'b0, tx_sh[7:1]};
                            tx_line <= tx_sh[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (tx_cnt == 16'd0) begin
                        if (tx_pop) begin
                            tx_sh    <= tx_dout;
                            tx_cnt   <= div;
                            tx_line  <= 1'b0;
                            tx_state <= START;
                        end else begin
                            tx_state <= IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Two-flop synchronizer plus previous sample for edge detect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_in;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX sampler: mid-bit sampling, glitch reject, framing check.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state   <= IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_wait_hi <= 1'b0;
        end else begin
            unique case (rx_state)
                IDLE: begin
                    if (rx_wait_hi) begin
                        if (rx_s2)
                            rx_wait_hi <= 1'b0;
                    end else if (rx_prev && !rx_s2) begin
                        rx_cnt   <= rx_wait;
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_cnt == 16'd0) begin
                        if (!rx_s2) begin
                            rx_cnt   <= div;
                            rx_bit   <= '0;
                            rx_state <= DATA;
                        end else begin
                            rx_state <= IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_cnt <= div;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        if (rx_bit == 3'd7)
                            rx_state <= STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (rx_cnt == 16'd0) begin
                        rx_wait_hi <= !rx_s2;
                        rx_state   <= IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbus_uart.sv
// Directed bench for dbus_uart: bus decode, TX/RX framing, FIFOs,
// sticky flags, fifo clear, loopback build option and reset.
module tb_dbus_uart;
    localparam logic [15:0] A_DATA   = 16'h2000;
    localparam logic [15:0] A_STATUS = 16'h2001;
    localparam logic [15:0] A_DIV    = 16'h2002;
    localparam logic [15:0] A_CTRL   = 16'h2003;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rxd = 1'b1;
    logic txd;
    logic irq;

    int errors = 0;
    int checks = 0;

    if_dbus bus ();

    dbus_uart #(
        .BASE_ADR  (16'h2000),
        .TX_DEPTH  (4),
        .RX_DEPTH  (4),
        .DIV_RESET (16'd433)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dbus    (bus),
        .txd     (txd),
        .rxd     (rxd),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.adr = a;
        bus.re  = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
        d = bus.dat_i;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        bus.adr   = a;
        bus.dat_o = v;
        bus.we    = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic rw(input logic [15:0] a, input logic [15:0] v,
                      output logic [15:0] d);
        @(negedge clk);
        bus.adr   = a;
        bus.dat_o = v;
        bus.re    = 1'b1;
        bus.we    = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
        bus.we = 1'b0;
        d = bus.dat_i;
    endtask

    // One 8N1 frame at 4 clocks per bit (DIV=3).
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (4) @(negedge clk);
        end
        rxd = stop;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
    endtask

    initial begin
        logic [15:0] d;
        logic [9:0]  frame;
        logic        saw_low;

        bus.adr   = '0;
        bus.re    = 1'b0;
        bus.we    = 1'b0;
        bus.dat_o = '0;

        repeat (4) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check("reset_txd", {15'b0, txd}, 16'h0001);
        check("reset_irq", {15'b0, irq}, 16'h0000);
        rd(A_STATUS, d);
        check("reset_status", d, 16'h0001);
        @(negedge clk);
        check("dat_i_returns_0", bus.dat_i, 16'h0000);
        rd(A_DIV, d);
        check("reset_div", d, 16'd433);
        rd(A_CTRL, d);
        check("reset_ctrl", d, 16'h0000);
        rd(16'h2004, d);
        check("miss_above", d, 16'h0000);
        rd(16'h1FFF, d);
        check("miss_below", d, 16'h0000);

        // Divisor write and read+write in one cycle
        wr(A_DIV, 16'd3);
        rd(A_DIV, d);
        check("div_write", d, 16'd3);
        rw(A_DIV, 16'd5, d);
        check("rw_pre_write", d, 16'd3);
        rd(A_DIV, d);
        check("rw_post_write", d, 16'd5);
        wr(A_DIV, 16'd3);

        // TX of 8'h55
        wr(A_DATA, 16'h0055);
        frame = {1'b1, 8'h55, 1'b0};
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx55_bit%0d", i), {15'b0, txd},
                  {15'b0, frame[i]});
            repeat (4) @(negedge clk);
        end
        rd(A_STATUS, d);
        check("tx_done_status", d, 16'h0001);

        // RX of 8'hA3
        send_byte(8'hA3, 1'b1);
        repeat (3) @(negedge clk);
        check("rx_irq", {15'b0, irq}, 16'h0001);
        rd(A_STATUS, d);
        check("rx_status", d, 16'h0005);
        rd(A_DATA, d);
        check("rx_data", d, 16'h80A3);
        rd(A_DATA, d);
        check("rx_empty_read", d, 16'h0000);

        // Overrun with five frames into a 4-deep FIFO
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (3) @(negedge clk);
        rd(A_STATUS, d);
        check("ovr_status", d, 16'h001D);
        rd(A_STATUS, d);
        check("ovr_cleared", d, 16'h000D);
        rd(A_DATA, d);
        check("ovr_byte1", d, 16'h8011);
        rd(A_DATA, d);
        check("ovr_byte2", d, 16'h8022);
        rd(A_DATA, d);
        check("ovr_byte3", d, 16'h8033);
        rd(A_DATA, d);
        check("ovr_byte4", d, 16'h8044);
        rd(A_DATA, d);
        check("ovr_drained", d, 16'h0000);

        // Framing error, then a one-clock glitch
        send_byte(8'h5A, 1'b0);
        repeat (3) @(negedge clk);
        rd(A_STATUS, d);
        check("ferr_status", d, 16'h0021);
        rd(A_STATUS, d);
        check("ferr_cleared", d, 16'h0001);
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (50) @(negedge clk);
        rd(A_STATUS, d);
        check("glitch_ignored", d, 16'h0001);

        // TX overflow, drop flag, fifo clear, tx interrupt
        for (int i = 0; i < 6; i++)
            wr(A_DATA, 16'h0040 + 16'(i));
        rd(A_STATUS, d);
        check("tx_drop_status", d, 16'h0042);
        wr(A_CTRL, 16'h0002);
        rd(A_STATUS, d);
        check("fifo_clr_status", d, 16'h0000);
        repeat (50) @(negedge clk);
        rd(A_STATUS, d);
        check("after_clr_idle", d, 16'h0001);
        wr(A_CTRL, 16'h0001);
        rd(A_CTRL, d);
        check("ctrl_tx_ie", d, 16'h0001);
        check("tx_irq", {15'b0, irq}, 16'h0001);
        wr(A_CTRL, 16'h0000);
        check("tx_irq_off", {15'b0, irq}, 16'h0000);

`ifdef DBUS_UART_LOOPBACK_EN
        wr(A_CTRL, 16'h0004);
        rd(A_CTRL, d);
        check("ctrl_loopback", d, 16'h0004);
        wr(A_DATA, 16'h003C);
        saw_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd !== 1'b1)
                saw_low = 1'b1;
        end
        check("loop_txd_high", {15'b0, saw_low}, 16'h0000);
        rd(A_DATA, d);
        check("loop_data", d, 16'h803C);
        wr(A_CTRL, 16'h0000);
`else
        saw_low = 1'b0;
        wr(A_CTRL, 16'h0004);
        rd(A_CTRL, d);
        check("ctrl_no_loopback", d, 16'h0000);
        check("no_loop_flag", {15'b0, saw_low}, 16'h0000);
`endif

        // Reset in the middle of a frame
        wr(A_DATA, 16'h0000);
        repeat (10) @(negedge clk);
        check("midframe_txd_low", {15'b0, txd}, 16'h0000);
        reset_n = 1'b0;
        @(negedge clk);
        check("reset_txd_high", {15'b0, txd}, 16'h0001);
        reset_n = 1'b1;
        rd(A_STATUS, d);
        check("post_reset_status", d, 16'h0001);
        rd(A_DIV, d);
        check("post_reset_div", d, 16'd433);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
